jtkunio_obj_scan: RTL and testbench



---
 rtl/jtkunio_obj_pkg.sv | 31 +++
 rtl/jtkunio_obj_draw.sv | 50 +++++
 rtl/jtkunio_obj_scan.sv | 172 +++++++++++++++++
 tb/tb_jtkunio_obj_scan.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_obj_pkg.sv
// Shared definitions for the Kunio object line scanner: FSM states,
// object attribute layout, sprite heights and the row/flip helper.
package jtkunio_obj_pkg;

    typedef enum logic [3:0] {
        IDLE, RD_Y, CHK, RD_ATTR, RD_CODE, RD_X, REQ, WAIT, DRAW, NEXT
    } state_t;

    localparam int OBJMAX_DEF = 64;
    localparam int PIX_BITS   = 4;

    // attr byte = {hflip, vflip, pal[1:0], tall, code_hi[2:0]}
    localparam int A_HFLIP = 7;
    localparam int A_VFLIP = 6;
    localparam int A_PAL   = 4;
    localparam int A_TALL  = 3;

    localparam logic [7:0] HGT_NORMAL = 8'd16;
    localparam logic [7:0] HGT_TALL   = 8'd32;

    // Row inside the sprite; vertical flip mirrors over 32 rows for tall
    // sprites and over 16 rows otherwise.
    function automatic logic [4:0] obj_row(input logic [4:0] yd, input logic tall,
                                           input logic vf);
        logic [4:0] r;
        r = yd;
        if (vf) r = tall ? ~yd : {yd[4], ~yd[3:0]};
        return r;
    endfunction

endpackage

// File: rtl/jtkunio_obj_draw.sv
// ROM word latch plus 8-cycle nibble serializer. Handles horizontal flip,
// transparency (pixel 0 is not written) and x wrap-around.
import jtkunio_obj_pkg::*;

module jtkunio_obj_draw (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [31:0] word_in,
    input  logic        en,
    input  logic [2:0]  k,
    input  logic        hflip,
    input  logic [1:0]  pal,
    input  logic [7:0]  base,
    output logic        buf_we,
    output logic [7:0]  buf_addr,
    output logic [5:0]  buf_din
);
    logic [31:0]         word;
    logic [2:0]          sel;
    logic [PIX_BITS-1:0] nib;

    // Pick nibble k, or 7-k when mirrored.
    always_comb begin
        sel = hflip ? ~k : k;
        nib = word[{sel, 2'b00} +: PIX_BITS];
    end

    // Hold the fetched ROM word for the duration of the draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  word <= '0;
        else if (ld) word <= word_in;
    end

    // Registered buffer write; address and data move together with the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
        end else if (en) begin
            buf_we   <= nib != '0;
            buf_addr <= base + {5'd0, k};
            buf_din  <= {pal, nib};
        end else begin
            buf_we   <= 1'b0;
        end
    end

endmodule

// File: rtl/jtkunio_obj_scan.sv
// Per-line object scanner: walks the object RAM at each line start, keeps
// the objects that cover the line being prepared, fetches their two ROM
// words and hands them to the serializer that fills the line buffer.
import jtkunio_obj_pkg::*;

module jtkunio_obj_scan #(
    parameter int OBJMAX = OBJMAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic [7:0]  vrender,
    input  logic        flip,
    output logic [7:0]  scan_addr,
    input  logic [7:0]  scan_dout,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic        buf_we,
    output logic [7:0]  buf_addr,
    output logic [5:0]  buf_din,
    output logic        busy
);
    localparam logic [5:0] NLAST = 6'(OBJMAX - 1);

    state_t      st;
    logic [5:0]  n, n_inc;
    logic        last, half, n_last;
    logic [2:0]  cnt;
    logic [7:0]  y_r, attr_r, code_lo_r, x_r, ydiff;
    logic [4:0]  ydiff_r, row;
    logic        hit, vf, hf, draw_en, ld;
    logic [10:0] code;
    logic [7:0]  base;

    // The scan address is issued one state ahead: by CHK both y and attr
    // have arrived, so a miss (including a short sprite at ydiff 16..31)
    // is resolved there and costs only RD_Y, CHK, NEXT.
    always_comb begin
        ydiff   = vrender - y_r;
        hit     = ydiff < (scan_dout[A_TALL] ? HGT_TALL : HGT_NORMAL);
        n_last  = n == NLAST;
        n_inc   = n_last ? 6'd0 : n + 6'd1;
        vf      = attr_r[A_VFLIP] ^ flip;
        hf      = attr_r[A_HFLIP] ^ flip;
        row     = obj_row(ydiff_r, attr_r[A_TALL], vf);
        code    = {attr_r[2:0], code_lo_r[7:1], code_lo_r[0] | (attr_r[A_TALL] & row[4])};
        base    = x_r + {4'd0, half ^ hf, 3'd0};
        draw_en = (st == DRAW) && !hs;
        ld      = (st == WAIT) && rom_ok && !hs;
    end

    // Scan FSM; hs restarts from object 0 in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            n         <= '0;
            last      <= 1'b0;
            half      <= 1'b0;
            cnt       <= '0;
            y_r       <= '0;
            attr_r    <= '0;
            code_lo_r <= '0;
            x_r       <= '0;
            ydiff_r   <= '0;
            scan_addr <= '0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            busy      <= 1'b0;
        end else if (hs) begin
            n      <= '0;
            last   <= 1'b0;
            rom_cs <= 1'b0;
            busy   <= 1'b1;
            if (st == IDLE) begin
                // address 0 is already on the bus while idle
                st        <= RD_Y;
                scan_addr <= 8'd1;
            end else begin
                st        <= NEXT;
                scan_addr <= 8'd0;
            end
        end else begin
            case (st)
                IDLE: ;
                RD_Y: begin
                    y_r       <= scan_dout;
                    scan_addr <= {n, 2'd2};
                    st        <= CHK;
                end
                CHK: begin
                    attr_r  <= scan_dout;
                    ydiff_r <= ydiff[4:0];
                    if (hit) begin
                        scan_addr <= {n, 2'd3};
                        st        <= RD_ATTR;
                    end else begin
                        scan_addr <= {n_inc, 2'd0};
                        n         <= n_inc;
                        last      <= n_last;
                        st        <= NEXT;
                    end
                end
                RD_ATTR: begin
                    code_lo_r <= scan_dout;
                    st        <= RD_CODE;
                end
                RD_CODE: begin
                    x_r <= scan_dout;
                    st  <= RD_X;
                end
                RD_X: begin
                    rom_addr <= {2'b00, code, row[3:0], 1'b0};
                    half     <= 1'b0;
                    rom_cs   <= 1'b1;
                    st       <= REQ;
                end
                REQ: st <= WAIT;   // rom_ok not trusted right after an address change
                WAIT: begin
                    if (rom_ok) begin
                        rom_cs <= 1'b0;
                        cnt    <= '0;
                        st     <= DRAW;
                    end
                end
                DRAW: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (!half) begin
                            half        <= 1'b1;
                            rom_addr[0] <= 1'b1;
                            rom_cs      <= 1'b1;
                            st          <= REQ;
                        end else begin
                            scan_addr <= {n_inc, 2'd0};
                            n         <= n_inc;
                            last      <= n_last;
                            st        <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (last) begin
                        busy <= 1'b0;
                        st   <= IDLE;
                    end else begin
                        scan_addr <= {n, 2'd1};
                        st        <= RD_Y;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    jtkunio_obj_draw u_draw (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .word_in  (rom_data),
        .en       (draw_en),
        .k        (cnt),
        .hflip    (hf),
        .pal      (attr_r[A_PAL +: 2]),
        .base     (base),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .buf_din  (buf_din)
    );

endmodule

// File: tb/tb_jtkunio_obj_scan.sv
// Bench for jtkunio_obj_scan: object RAM, ROM slot and line-buffer models
// around the DUT, a table of single-sprite scenarios, and hand-written
// sequences for the all-miss line and the abort-during-fetch case.
module tb_jtkunio_obj_scan;

    logic        clk = 1'b0, rst_n = 1'b0, hs = 1'b0, flip = 1'b0;
    logic [7:0]  vrender = '0, scan_addr, scan_dout = '0;
    logic        rom_cs, rom_ok = 1'b0, buf_we, busy;
    logic [17:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic [7:0]  buf_addr;
    logic [5:0]  buf_din;

    always #5 clk = ~clk;

    jtkunio_obj_scan #(.OBJMAX(64)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vrender(vrender), .flip(flip),
        .scan_addr(scan_addr), .scan_dout(scan_dout),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din), .busy(busy)
    );

    int npass = 0, ntot = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // object RAM: synchronous read, data one cycle after the address
    logic [7:0] mem [256];
    always @(posedge clk) scan_dout <= mem[scan_addr];

    // ROM slot, line buffer capture and request log
    int          lat = 2, wcnt = 0, nwr = 0, nreq = 0, unstable = 0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [5:0]  lb  [256];
    int          lbn [256];
    logic [17:0] rq  [8];
    logic        cs_q = 1'b0;
    logic [17:0] ra_q = '0;
    always @(negedge clk) begin
        if (buf_we) begin
            lb[buf_addr] = buf_din;
            lbn[buf_addr]++;
            nwr++;
        end
        if (rom_cs && !cs_q) begin
            if (nreq < 8) rq[nreq] = rom_addr;
            nreq++;
        end
        if (rom_cs && cs_q && rom_addr != ra_q) unstable++;
        cs_q = rom_cs;
        ra_q = rom_addr;
        wcnt = rom_cs ? wcnt + 1 : 0;
        rom_ok = rom_cs && (wcnt > lat);
        rom_data = rom_addr[0] ? d1 : d0;
    end

    typedef struct {
        logic [7:0]  vr;
        logic        flip;
        logic [7:0]  y, attr, code, x;
        int          lat;
        logic [31:0] d0, d1;
        logic [17:0] ra0;
        logic [7:0]  bx0;     // screen x of pix nibble 0
        logic [63:0] pix;     // nibble i = pixel expected at bx0+i (0 = no write)
        logic [1:0]  pal;
        int          busy;    // expected busy length, one hit + 63 misses
    } vec_t;

    vec_t vecs [6];

    task automatic load_ram(input logic [7:0] y0, input logic [7:0] a0,
                            input logic [7:0] c0, input logic [7:0] x0);
        for (int i = 0; i < 256; i++) mem[i] = (i % 4 == 0) ? 8'hF0 : 8'h00;
        mem[0] = y0; mem[1] = a0; mem[2] = c0; mem[3] = x0;
        for (int i = 0; i < 256; i++) begin lb[i] = '0; lbn[i] = 0; end
        nwr = 0; nreq = 0; unstable = 0;
    endtask

    // one hs pulse, then wait out the scan; returns busy length
    task automatic scan_line(input string tag, output int blen);
        int guard;
        @(negedge clk); hs = 1'b1;
        chk({tag, "_busy_pre"}, 64'(busy), 64'd0);
        @(negedge clk); hs = 1'b0;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        blen = 0; guard = 0;
        while (busy && guard < 5000) begin blen++; @(negedge clk); guard++; end
        if (guard >= 5000) chk({tag, "_timeout"}, 64'(guard), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_pixels(input string tag, input vec_t v);
        int bad, nz;
        logic [7:0] a;
        logic [3:0] p;
        bad = 0; nz = 0;
        for (int i = 0; i < 16; i++) begin
            a = v.bx0 + 8'(i);
            p = v.pix[i*4 +: 4];
            if (p != 0) begin
                nz++;
                if (lbn[a] != 1 || lb[a] != {v.pal, p}) bad++;
            end else if (lbn[a] != 0) bad++;
        end
        chk({tag, "_pixels_bad"}, 64'(bad), 64'd0);
        chk({tag, "_writes"}, 64'(nwr), 64'(nz));
    endtask

    initial begin
        int blen, guard;
        vecs[0] = '{8'h45, 1'b0, 8'h40, 8'h21, 8'h23, 8'h10, 2, 32'h87654321, 32'hFEDCBA98,
                    18'h0246A, 8'h10, 64'hFEDCBA98_87654321, 2'd2, 217};
        vecs[1] = '{8'h45, 1'b0, 8'h40, 8'hA1, 8'h23, 8'h10, 1, 32'h87654321, 32'hFEDCBA98,
                    18'h0246A, 8'h10, 64'h12345678_89ABCDEF, 2'd2, 215};
        vecs[2] = '{8'h45, 1'b0, 8'h40, 8'h21, 8'h23, 8'hFC, 3, 32'h70605040, 32'h900000A1,
                    18'h0246A, 8'hFC, 64'h900000A1_70605040, 2'd2, 219};
        vecs[3] = '{8'h28, 1'b0, 8'h10, 8'h1A, 8'h44, 8'h80, 2, 32'h11111111, 32'h22222222,
                    18'h048B0, 8'h80, 64'h22222222_11111111, 2'd1, 217};
        vecs[4] = '{8'h28, 1'b1, 8'h10, 8'h1A, 8'h44, 8'h80, 4, 32'h11111111, 32'h22222222,
                    18'h0488E, 8'h80, 64'h11111111_22222222, 2'd1, 221};
        vecs[5] = '{8'h45, 1'b0, 8'h40, 8'h61, 8'h23, 8'h10, 1, 32'h87654321, 32'hFEDCBA98,
                    18'h02474, 8'h10, 64'hFEDCBA98_87654321, 2'd2, 215};

        load_ram(8'hF0, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_scan_addr", 64'(scan_addr), 64'd0);
        chk("rst_rom_cs",    64'(rom_cs),    64'd0);
        chk("rst_rom_addr",  64'(rom_addr),  64'd0);
        chk("rst_buf_we",    64'(buf_we),    64'd0);
        chk("rst_buf_addr",  64'(buf_addr),  64'd0);
        chk("rst_buf_din",   64'(buf_din),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);

        // every object at y=0xF0 on line 0: ydiff 16 on a short sprite misses
        vrender = 8'h00; flip = 1'b0;
        scan_line("miss", blen);
        chk("miss_busy_len", 64'(blen), 64'd192);
        chk("miss_rom_req",  64'(nreq), 64'd0);
        chk("miss_writes",   64'(nwr),  64'd0);

        for (int t = 0; t < 6; t++) begin
            string tag;
            tag = $sformatf("v%0d", t);
            load_ram(vecs[t].y, vecs[t].attr, vecs[t].code, vecs[t].x);
            vrender = vecs[t].vr; flip = vecs[t].flip; lat = vecs[t].lat;
            d0 = vecs[t].d0; d1 = vecs[t].d1;
            scan_line(tag, blen);
            chk({tag, "_nreq"},     64'(nreq), 64'd2);
            chk({tag, "_rom_addr0"}, 64'(rq[0]), 64'(vecs[t].ra0));
            chk({tag, "_rom_addr1"}, 64'(rq[1]), 64'(vecs[t].ra0 | 18'd1));
            chk({tag, "_addr_stable"}, 64'(unstable), 64'd0);
            chk({tag, "_busy_len"}, 64'(blen), 64'(vecs[t].busy));
            chk_pixels(tag, vecs[t]);
        end

        // hs during WAIT aborts the fetch and restarts at object 0
        load_ram(vecs[0].y, vecs[0].attr, vecs[0].code, vecs[0].x);
        vrender = vecs[0].vr; flip = 1'b0; lat = 40;
        d0 = vecs[0].d0; d1 = vecs[0].d1;
        @(negedge clk); hs = 1'b1;
        @(negedge clk); hs = 1'b0;
        guard = 0;
        while (!rom_cs && guard < 100) begin @(negedge clk); guard++; end
        chk("abort_req_seen", 64'(rom_cs), 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_pre_cs", 64'(rom_cs), 64'd1);
        hs = 1'b1;
        @(negedge clk); hs = 1'b0; lat = 2;
        chk("abort_cs_low",    64'(rom_cs),    64'd0);
        chk("abort_busy",      64'(busy),      64'd1);
        chk("abort_scan_addr0", 64'(scan_addr), 64'd0);
        chk("abort_no_we",     64'(buf_we),    64'd0);
        @(negedge clk);
        chk("abort_scan_addr1", 64'(scan_addr), 64'd1);
        chk("abort_writes_pre", 64'(nwr), 64'd0);
        guard = 0;
        while (busy && guard < 5000) begin @(negedge clk); guard++; end
        chk("abort_done", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_nreq",      64'(nreq),  64'd3);
        chk("abort_rom_addr1", 64'(rq[1]), 64'h0246A);
        chk("abort_rom_addr2", 64'(rq[2]), 64'h0246B);
        chk_pixels("abort", vecs[0]);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
